// File: rtl/pwm_phase_sweep_if.sv
// AXI4-Lite register bus (32-bit data) used to configure the PWM phase sweeper.
interface pwm_phase_sweep_if #(
    parameter int AXI_AW = 8
);
    logic [AXI_AW-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AXI_AW-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/pwm_phase_sweep.sv
// Per-channel phase sweeper: on a selected PWM edge, steps the channel phase by a
// signed amount modulo the PWM period and strobes the new value to the generator.
module pwm_phase_sweep #(
    parameter int PWM_CNT       = 4,
    parameter int PWM_CNT_WIDTH = 12,
    parameter int AXI_AW        = 8
) (
    input  logic                             ACLK,
    input  logic                             ARESETn,
    pwm_phase_sweep_if.slave                 s_axi,
    input  logic [PWM_CNT-1:0]               pwm_sig,
    input  logic [PWM_CNT_WIDTH-1:0]         pwm_period,
    input  logic [PWM_CNT*PWM_CNT_WIDTH-1:0] pwm_phase_in,
    output logic [PWM_CNT*PWM_CNT_WIDTH-1:0] pwm_phase_out,
    output logic [PWM_CNT-1:0]               pwm_phase_we
);
    localparam int W  = PWM_CNT_WIDTH;
    localparam int HW = AXI_AW - 4;
    // Wide enough for acc + step + P without overflow, for either a 16-bit step or wide counters.
    localparam int SW = ((W > 16) ? W : 16) + 2;

    // Word-aligned address is channel block `ch` (base 0x10 + 0x10*ch) at word offset `off`.
    function automatic logic ch_hit(input logic [AXI_AW-1:0] a, input int ch, input logic [1:0] off);
        return (a[AXI_AW-1:4] == HW'(ch + 1)) && (a[3:2] == off) && (a[1:0] == 2'b00);
    endfunction

    // ---------------- AXI-Lite write/read channels ----------------
    logic              aw_full, w_full, bvalid_q, rvalid_q;
    logic [AXI_AW-1:0] aw_addr_q;
    logic [31:0]       w_data_q, rdata_q, rd_mux;
    logic              wr_commit;

    assign wr_commit     = aw_full && w_full;
    assign s_axi.awready = !aw_full && !bvalid_q;
    assign s_axi.wready  = !w_full && !bvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = !rvalid_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;

    // Capture AW and W independently; commit once both slots hold a beat, then raise BVALID.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            bvalid_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
        end else begin
            if (s_axi.awvalid && s_axi.awready) begin
                aw_full   <= 1'b1;
                aw_addr_q <= s_axi.awaddr;
            end
            if (s_axi.wvalid && s_axi.wready) begin
                w_full   <= 1'b1;
                w_data_q <= s_axi.wdata;
            end
            if (wr_commit) begin
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
                bvalid_q <= 1'b1;
            end else if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // ---------------- Configuration registers ----------------
    logic               run;
    logic [PWM_CNT-1:0] ch_en, load, edge_sel;
    logic [15:0]        step     [PWM_CNT];
    logic [7:0]         skip     [PWM_CNT];
    logic [7:0]         cnt      [PWM_CNT];

    // Sweep state
    logic [PWM_CNT-1:0] busy, forever_q, active_q, pwm_q, phase_we_q;
    logic [7:0]         steps_left [PWM_CNT];
    logic [7:0]         skip_ctr   [PWM_CNT];
    logic [W-1:0]       acc        [PWM_CNT];
    logic [W-1:0]       phase_out  [PWM_CNT];
    logic [W-1:0]       nxt_acc    [PWM_CNT];
    logic [PWM_CNT-1:0] active, start, edge_hit;

    // Apply committed writes to GLOBAL / CTRL / CFG; STATUS and holes ignore writes.
    // NOTE: these register arrays are small control state, so every entry is reset explicitly.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            run      <= 1'b0;
            ch_en    <= '0;
            load     <= '0;
            edge_sel <= '0;
            for (int ch = 0; ch < PWM_CNT; ch++) begin
                step[ch] <= '0;
                skip[ch] <= '0;
                cnt[ch]  <= '0;
            end
        end else if (wr_commit) begin
            if (aw_addr_q == '0) run <= w_data_q[0];
            for (int ch = 0; ch < PWM_CNT; ch++) begin
                if (ch_hit(aw_addr_q, ch, 2'd0)) begin
                    ch_en[ch]    <= w_data_q[0];
                    load[ch]     <= w_data_q[1];
                    edge_sel[ch] <= w_data_q[4];
                end
                if (ch_hit(aw_addr_q, ch, 2'd1)) begin
                    step[ch] <= w_data_q[31:16];
                    skip[ch] <= w_data_q[15:8];
                    cnt[ch]  <= w_data_q[7:0];
                end
            end
        end
    end

    // Read decode: GLOBAL, then per-channel CTRL/CFG/STATUS; everything else reads 0.
    // NOTE: assign a default before any branch so no path leaves rd_mux unassigned (no latch).
    always_comb begin
        rd_mux = '0;
        if (s_axi.araddr == '0) rd_mux = {31'b0, run};
        for (int ch = 0; ch < PWM_CNT; ch++) begin
            if (ch_hit(s_axi.araddr, ch, 2'd0)) rd_mux = {27'b0, edge_sel[ch], 2'b00, load[ch], ch_en[ch]};
            if (ch_hit(s_axi.araddr, ch, 2'd1)) rd_mux = {step[ch], skip[ch], cnt[ch]};
            if (ch_hit(s_axi.araddr, ch, 2'd2)) begin
                rd_mux[31]    = busy[ch];
                rd_mux[23:16] = steps_left[ch];
                rd_mux[W-1:0] = acc[ch];
            end
        end
    end

    // Register the read data on the AR handshake; hold RVALID until RREADY.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (s_axi.arvalid && s_axi.arready) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // ---------------- Sweep engine ----------------
    assign active   = {PWM_CNT{run}} & ch_en;
    assign start    = active & ~active_q;
    assign edge_hit = (edge_sel & pwm_q & ~pwm_sig) | (~edge_sel & pwm_sig & ~pwm_q);

    // Next phase: (acc + step) mod P. Adding P first keeps the dividend non-negative for
    // |step| < P; the modulo also folds an acc left over from a larger period.
    always_comb begin
        for (int ch = 0; ch < PWM_CNT; ch++) begin
            nxt_acc[ch] = acc[ch];
            if (pwm_period != '0)
                nxt_acc[ch] = W'(({{(SW-W){1'b0}}, acc[ch]}
                                + {{(SW-16){step[ch][15]}}, step[ch]}
                                + {{(SW-W){1'b0}}, pwm_period})
                                % {{(SW-W){1'b0}}, pwm_period});
            pwm_phase_out[ch*W +: W] = phase_out[ch];
        end
    end

    assign pwm_phase_we = phase_we_q;

    // Per-channel start / abort / skip / step sequencing on detected PWM edges.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            busy       <= '0;
            forever_q  <= '0;
            active_q   <= '0;
            pwm_q      <= '0;
            phase_we_q <= '0;
            for (int ch = 0; ch < PWM_CNT; ch++) begin
                steps_left[ch] <= '0;
                skip_ctr[ch]   <= '0;
                acc[ch]        <= '0;
                phase_out[ch]  <= '0;
            end
        end else begin
            active_q   <= active;
            pwm_q      <= pwm_sig;
            phase_we_q <= '0;
            for (int ch = 0; ch < PWM_CNT; ch++) begin
                if (!active[ch]) begin
                    busy[ch] <= 1'b0;
                end else if (start[ch]) begin
                    busy[ch]       <= 1'b1;
                    steps_left[ch] <= cnt[ch];
                    skip_ctr[ch]   <= skip[ch];
                    forever_q[ch]  <= (cnt[ch] == 8'd0);
                    if (load[ch]) acc[ch] <= pwm_phase_in[ch*W +: W];
                end else if (busy[ch] && edge_hit[ch] && (pwm_period != '0)) begin
                    if (skip_ctr[ch] != 8'd0) begin
                        skip_ctr[ch] <= skip_ctr[ch] - 8'd1;
                    end else begin
                        acc[ch]        <= nxt_acc[ch];
                        phase_out[ch]  <= nxt_acc[ch];
                        phase_we_q[ch] <= 1'b1;
                        skip_ctr[ch]   <= skip[ch];
                        if (!forever_q[ch]) begin
                            steps_left[ch] <= steps_left[ch] - 8'd1;
                            if (steps_left[ch] == 8'd1) busy[ch] <= 1'b0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_phase_sweep.sv
// Directed bench for pwm_phase_sweep: register access, sweep arithmetic, abort/restart,
// period boundaries and AXI-Lite channel ordering/back-pressure.
module tb_pwm_phase_sweep;
    localparam int N = 4;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_phase_sweep_if #(.AXI_AW(8)) bus ();

    logic [N-1:0]   pwm_sig;
    logic [W-1:0]   pwm_period;
    logic [N*W-1:0] pwm_phase_in;
    logic [N*W-1:0] pwm_phase_out;
    logic [N-1:0]   pwm_phase_we;

    pwm_phase_sweep #(.PWM_CNT(N), .PWM_CNT_WIDTH(W), .AXI_AW(8)) dut (
        .ACLK         (clk),
        .ARESETn      (rst_n),
        .s_axi        (bus.slave),
        .pwm_sig      (pwm_sig),
        .pwm_period   (pwm_period),
        .pwm_phase_in (pwm_phase_in),
        .pwm_phase_out(pwm_phase_out),
        .pwm_phase_we (pwm_phase_we)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: counts strobes per channel, logs values, counts ch0/ch1 misalignment.
    int           strobes [N];
    logic [W-1:0] vals    [N][128];
    int           skew = 0;
    always @(negedge clk) begin
        if (pwm_phase_we[0] !== pwm_phase_we[1]) skew <= skew + 1;
        for (int ch = 0; ch < N; ch++) begin
            if (pwm_phase_we[ch] === 1'b1) begin
                if (strobes[ch] < 128) vals[ch][strobes[ch]] <= pwm_phase_out[ch*W +: W];
                strobes[ch] <= strobes[ch] + 1;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic aw_only(input logic [7:0] a);
        logic rdy;
        bit ok = 0;
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            rdy = bus.awready;
            tick();
            if (rdy) begin ok = 1; break; end
        end
        bus.awvalid = 1'b0;
        check("aw_hs", ok, 1);
    endtask

    task automatic w_only(input logic [31:0] d);
        logic rdy;
        bit ok = 0;
        bus.wdata  = d;
        bus.wvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            rdy = bus.wready;
            tick();
            if (rdy) begin ok = 1; break; end
        end
        bus.wvalid = 1'b0;
        check("w_hs", ok, 1);
    endtask

    // Waits for BVALID, keeps BREADY low for `hold` clocks checking it stays put, then accepts.
    task automatic b_take(input int hold);
        bit seen = 0;
        bit stable;
        for (int n = 0; n < 50; n++) begin
            if (bus.bvalid) begin seen = 1; break; end
            tick();
        end
        stable = seen && (bus.bresp == 2'b00);
        for (int n = 0; n < hold; n++) begin
            tick();
            if (!bus.bvalid || bus.bresp != 2'b00) stable = 0;
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("b_hs", {seen, stable, bus.bvalid}, 3'b110);
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d);
        fork
            aw_only(a);
            w_only(d);
        join
        b_take(0);
    endtask

    task automatic axi_read(input logic [7:0] a, input int hold, output logic [31:0] d);
        logic rdy;
        bit ok = 0, seen = 0, stable;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            rdy = bus.arready;
            tick();
            if (rdy) begin ok = 1; break; end
        end
        bus.arvalid = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (bus.rvalid) begin seen = 1; break; end
            tick();
        end
        d = bus.rdata;
        stable = seen && (bus.rresp == 2'b00);
        for (int n = 0; n < hold; n++) begin
            tick();
            if (!bus.rvalid || bus.rdata !== d) stable = 0;
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("r_hs", {ok, seen, stable, bus.rvalid}, 4'b1110);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, 0, d);
        check(tag, d, exp);
    endtask

    // n PWM periods on every channel: high 2 clocks, low 2 clocks.
    task automatic pwm_periods(input int n);
        for (int i = 0; i < n; i++) begin
            pwm_sig = '1;
            repeat (2) tick();
            pwm_sig = '0;
            repeat (2) tick();
        end
        repeat (3) tick();
    endtask

    int          base0, base1, base2, skew0;
    logic [31:0] d;

    initial begin
        bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
        pwm_sig = '0;
        pwm_period = 12'd1250;
        pwm_phase_in = '0;

        // ---- 1: reset state and register read-back ----
        do_reset();
        check("rst_ready", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b11100);
        check("rst_we", pwm_phase_we, 0);
        check("rst_out", pwm_phase_out, 0);
        rd_chk("rst_global", 8'h00, 32'h0);
        for (int ch = 0; ch < N; ch++)
            for (int off = 0; off < 3; off++)
                rd_chk($sformatf("rst_ch%0d_off%0d", ch, off*4), 8'(8'h10 + 16*ch + 4*off), 32'h0);
        axi_write(8'h30, 32'h0000_0013);
        axi_write(8'h34, 32'hFFCE_0020);
        rd_chk("rb_ctrl2", 8'h30, 32'h0000_0013);
        rd_chk("rb_cfg2", 8'h34, 32'hFFCE_0020);

        // ---- 3: ch2 step -50, 32 steps on falling edges, from phase 0 ----
        base2 = strobes[2];
        axi_write(8'h00, 32'h1);
        rd_chk("t3_status_start", 8'h38, 32'h8020_0000);
        pwm_periods(40);
        check("t3_count", strobes[2] - base2, 32);
        check("t3_first", vals[2][base2], 1200);
        check("t3_second", vals[2][base2+1], 1150);
        check("t3_final", vals[2][base2+31], 900);
        rd_chk("t3_status_end", 8'h38, 32'h0000_0384);

        // ---- 2: ch1 load 625, step +25, skip 10, runs forever ----
        do_reset();
        pwm_phase_in[1*W +: W] = 12'd625;
        axi_write(8'h20, 32'h0000_0013);
        axi_write(8'h24, 32'h0019_0A00);
        base1 = strobes[1];
        axi_write(8'h00, 32'h1);
        pwm_periods(34);
        check("t2_count", strobes[1] - base1, 3);
        check("t2_v0", vals[1][base1], 650);
        check("t2_v1", vals[1][base1+1], 675);
        check("t2_v2", vals[1][base1+2], 700);
        rd_chk("t2_status", 8'h28, 32'h8000_02BC);
        pwm_phase_in = '0;

        // ---- 4: ch0/ch1 identical config, one GLOBAL write -> strobes in the same cycle ----
        do_reset();
        axi_write(8'h10, 32'h1);
        axi_write(8'h14, 32'h0064_0002);
        axi_write(8'h20, 32'h1);
        axi_write(8'h24, 32'h0064_0002);
        base0 = strobes[0]; base1 = strobes[1]; skew0 = skew;
        axi_write(8'h00, 32'h1);
        pwm_periods(4);
        check("t4_cnt0", strobes[0] - base0, 2);
        check("t4_cnt1", strobes[1] - base1, 2);
        check("t4_skew", skew - skew0, 0);
        check("t4_ch0_v1", vals[0][base0+1], 200);
        check("t4_ch1_v0", vals[1][base1], 100);
        rd_chk("t4_status0", 8'h18, 32'h0000_00C8);

        // ---- 5: abort mid-sweep, restart reloads, P=0 hold, shrunken P ----
        do_reset();
        axi_write(8'h10, 32'h1);
        axi_write(8'h14, 32'h000A_000A);
        base0 = strobes[0];
        axi_write(8'h00, 32'h1);
        pwm_periods(3);
        check("t5_cnt_run", strobes[0] - base0, 3);
        axi_write(8'h00, 32'h0);
        rd_chk("t5_status_abort", 8'h18, 32'h0007_001E);
        pwm_periods(3);
        check("t5_cnt_stopped", strobes[0] - base0, 3);
        axi_write(8'h00, 32'h1);
        rd_chk("t5_status_restart", 8'h18, 32'h800A_001E);
        pwm_periods(1);
        check("t5_v_restart", vals[0][base0+3], 40);
        pwm_period = 12'd0;
        pwm_periods(3);
        check("t5_p0_cnt", strobes[0] - base0, 4);
        rd_chk("t5_p0_status", 8'h18, 32'h8009_0028);
        pwm_period = 12'd25;
        pwm_periods(1);
        check("t5_newp_val", vals[0][base0+4], 0);
        rd_chk("t5_newp_status", 8'h18, 32'h8008_0000);
        pwm_period = 12'd1250;

        // ---- 6: AXI ordering and back-pressure ----
        do_reset();
        aw_only(8'h14);
        repeat (2) tick();
        check("t6_aw_first_nob", {bus.bvalid, bus.wready}, 2'b01);
        w_only(32'h1234_5678);
        b_take(5);
        rd_chk("t6_aw_first_rb", 8'h14, 32'h1234_5678);
        w_only(32'hABCD_0102);
        repeat (2) tick();
        check("t6_w_first_nob", {bus.bvalid, bus.awready}, 2'b01);
        aw_only(8'h24);
        b_take(5);
        rd_chk("t6_w_first_rb", 8'h24, 32'hABCD_0102);
        axi_read(8'h24, 5, d);
        check("t6_r_hold_data", d, 32'hABCD_0102);
        rd_chk("t6_unmapped_f0", 8'hF0, 32'h0);
        rd_chk("t6_unmapped_04", 8'h04, 32'h0);
        check("t6_rresp", bus.rresp, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
